traffic_phase_controller: RTL and testbench

//  Downstream consumer of the adaptive green-time stage. Sequences the four-way

---
 rtl/traffic_phase_controller.sv | 133 +++++++++++++
 tb/tb_traffic_phase_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// Four-way intersection phase sequencer: green/yellow per direction,
// tick-driven phase timer, lamp decode and adaptation strobe.
module traffic_phase_controller #(
  parameter int TG_MIN   = 10,
  parameter int TG_MAX   = 120,
  parameter int YELLOW_T = 4,
  parameter int TG_INIT  = 54
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       hold,
  input  logic [7:0] TGn,
  input  logic [7:0] TGe,
  input  logic [7:0] TGs,
  input  logic [7:0] TGw,
  output logic [2:0] p_s,
  output logic [1:0] light_n,
  output logic [1:0] light_e,
  output logic [1:0] light_s,
  output logic [1:0] light_w,
  output logic [7:0] remain,
  output logic       adapt_strobe
);

  typedef enum logic [2:0] {
    N_GRN = 3'd0,
    N_YEL = 3'd1,
    E_GRN = 3'd2,
    E_YEL = 3'd3,
    S_GRN = 3'd4,
    S_YEL = 3'd5,
    W_GRN = 3'd6,
    W_YEL = 3'd7
  } phase_e;

  localparam logic [7:0] L_MIN = 8'(TG_MIN);
  localparam logic [7:0] L_MAX = 8'(TG_MAX);
  localparam logic [7:0] L_YEL = 8'(YELLOW_T);

  function automatic logic [7:0] clamp(input logic [7:0] tg);
    if (tg < L_MIN)
      return L_MIN;
    else if (tg > L_MAX)
      return L_MAX;
    else
      return tg;
  endfunction

  function automatic logic [1:0] lamp(
    input logic [2:0] st,
    input logic [1:0] dir
  );
    if (st[2:1] != dir)
      return 2'b00;
    else if (st[0])
      return 2'b01;
    else
      return 2'b10;
  endfunction

  localparam logic [7:0] L_INIT = clamp(8'(TG_INIT));

  phase_e     r_state;
  phase_e     w_state_nx;
  logic [7:0] r_remain;
  logic [7:0] w_remain_nx;
  logic       r_strobe;
  logic       w_strobe_nx;
  logic [1:0] r_light_n;
  logic [1:0] r_light_e;
  logic [1:0] r_light_s;
  logic [1:0] r_light_w;
  logic [2:0] w_adv;
  logic [7:0] w_tg;

  assign w_adv = r_state + 3'd1;

  // TG of the direction whose green would be loaded next
  always_comb begin
    w_tg = TGn;
    unique case (w_adv[2:1])
      2'd0: w_tg = TGn;
      2'd1: w_tg = TGe;
      2'd2: w_tg = TGs;
      2'd3: w_tg = TGw;
    endcase
  end

  always_comb begin
    w_state_nx  = r_state;
    w_remain_nx = r_remain;
    w_strobe_nx = 1'b0;
    if (tick && !hold) begin
      if (r_remain > 8'd1) begin
        w_remain_nx = r_remain - 8'd1;
      end else begin
        w_state_nx  = phase_e'(w_adv);
        w_remain_nx = w_adv[0] ? L_YEL : clamp(w_tg);
        w_strobe_nx = ~r_state[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= N_GRN;
      r_remain  <= L_INIT;
      r_strobe  <= 1'b0;
      r_light_n <= 2'b10;
      r_light_e <= 2'b00;
      r_light_s <= 2'b00;
      r_light_w <= 2'b00;
    end else begin
      r_state   <= w_state_nx;
      r_remain  <= w_remain_nx;
      r_strobe  <= w_strobe_nx;
      r_light_n <= lamp(w_state_nx, 2'd0);
      r_light_e <= lamp(w_state_nx, 2'd1);
      r_light_s <= lamp(w_state_nx, 2'd2);
      r_light_w <= lamp(w_state_nx, 2'd3);
    end
  end

  assign p_s          = r_state;
  assign remain       = r_remain;
  assign adapt_strobe = r_strobe;
  assign light_n      = r_light_n;
  assign light_e      = r_light_e;
  assign light_s      = r_light_s;
  assign light_w      = r_light_w;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: queued phase
// expectations popped and checked as the controller steps through.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       hold;
  logic [7:0] TGn, TGe, TGs, TGw;
  logic [2:0] p_s;
  logic [1:0] light_n, light_e, light_s, light_w;
  logic [7:0] remain;
  logic       adapt_strobe;

  always #5 clk = ~clk;

  traffic_phase_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .hold         (hold),
    .TGn          (TGn),
    .TGe          (TGe),
    .TGs          (TGs),
    .TGw          (TGw),
    .p_s          (p_s),
    .light_n      (light_n),
    .light_e      (light_e),
    .light_s      (light_s),
    .light_w      (light_w),
    .remain       (remain),
    .adapt_strobe (adapt_strobe)
  );

  typedef struct {
    logic [2:0] ps;
    int         dur;
    bit         strb;
    int         hold_at;
    int         chg_at;
    logic [7:0] chg_val;
    int         rst_at;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   strobes  = 0;
  bit   reset_hit;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_lamp(input logic [2:0] ps,
                                          input logic [1:0] dir);
    if (ps[2:1] != dir) return 2'b00;
    return ps[0] ? 2'b01 : 2'b10;
  endfunction

  task automatic chk_lamps(input logic [2:0] ps);
    chk("light_n", light_n, exp_lamp(ps, 2'd0));
    chk("light_e", light_e, exp_lamp(ps, 2'd1));
    chk("light_s", light_s, exp_lamp(ps, 2'd2));
    chk("light_w", light_w, exp_lamp(ps, 2'd3));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] ps, input int dur,
                      input bit strb, input int hold_at = 0,
                      input int chg_at = 0,
                      input logic [7:0] chg_val = 8'd0,
                      input int rst_at = 0);
    exp_t e;
    e.ps = ps; e.dur = dur; e.strb = strb;
    e.hold_at = hold_at; e.chg_at = chg_at;
    e.chg_val = chg_val; e.rst_at = rst_at;
    q.push_back(e);
  endtask

  task automatic pop_run();
    exp_t e;
    int   cnt;
    bit   done;
    e = q.pop_front();
    chk("ps_entry", p_s, e.ps);
    chk("remain_entry", remain, e.dur);
    chk("strobe_entry", adapt_strobe, e.strb);
    chk_lamps(e.ps);
    if (adapt_strobe) strobes++;
    cnt  = 0;
    done = 0;
    while (!done) begin
      if (e.hold_at != 0 && remain == e.hold_at) begin
        hold = 1'b1;
        repeat (20) begin
          step();
          chk("hold_ps", p_s, e.ps);
          chk("hold_remain", remain, e.hold_at);
          chk("hold_strobe", adapt_strobe, 1'b0);
        end
        hold = 1'b0;
        e.hold_at = 0;
      end
      if (e.chg_at != 0 && remain == e.chg_at) begin
        TGn = e.chg_val;
        e.chg_at = 0;
      end
      if (e.rst_at != 0 && remain == e.rst_at) begin
        reset_n = 1'b0;
        #1;
        reset_hit = 1'b1;
        return;
      end
      step();
      cnt++;
      if (p_s != e.ps || cnt > e.dur + 5) begin
        done = 1'b1;
      end else begin
        chk("remain_run", remain, e.dur - cnt);
        chk("strobe_run", adapt_strobe, 1'b0);
        chk_lamps(e.ps);
      end
    end
    chk("duration", cnt, e.dur);
  endtask

  task automatic pop_n(input int n);
    repeat (n) pop_run();
  endtask

  task automatic push_cycle15();
    push(3'd0, 15, 0); push(3'd1, 4, 1);
    push(3'd2, 15, 0); push(3'd3, 4, 1);
    push(3'd4, 15, 0); push(3'd5, 4, 1);
    push(3'd6, 15, 0); push(3'd7, 4, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    tick    = 1'b0;
    hold    = 1'b0;
    reset_hit = 1'b0;
    TGn = 8'd20; TGe = 8'd30; TGs = 8'd5; TGw = 8'd200;
    repeat (3) step();
    chk("rst_ps", p_s, 3'd0);
    chk("rst_remain", remain, 8'd54);
    chk("rst_strobe", adapt_strobe, 1'b0);
    chk_lamps(3'd0);

    tick    = 1'b1;
    reset_n = 1'b1;
    // cycle 1: reset green, clamp low (S) and high (W)
    push(3'd0, 54, 0); push(3'd1, 4, 1);
    push(3'd2, 30, 0); push(3'd3, 4, 1);
    push(3'd4, 10, 0); push(3'd5, 4, 1);
    push(3'd6, 120, 0); push(3'd7, 4, 1);
    pop_n(3);
    TGe = 8'hF6;
    pop_n(5);

    // cycle 2: late TGn change, wrapped TGe, hold in E_GRN
    push(3'd0, 20, 0, 0, 5, 8'd90);
    push(3'd1, 4, 1);
    push(3'd2, 120, 0, 7);
    push(3'd3, 4, 1);
    pop_n(3);
    TGe = 8'd15; TGs = 8'd15; TGw = 8'd15;
    push(3'd4, 15, 0); push(3'd5, 4, 1);
    push(3'd6, 15, 0); push(3'd7, 4, 1);
    pop_n(5);

    // cycle 3: new TGn takes effect
    push(3'd0, 90, 0); push(3'd1, 4, 1);
    push(3'd2, 15, 0); push(3'd3, 4, 1);
    push(3'd4, 15, 0); push(3'd5, 4, 1);
    push(3'd6, 15, 0); push(3'd7, 4, 1);
    pop_n(1);
    TGn = 8'd15;
    pop_n(7);

    // cycle 4: full uniform cycle
    strobes = 0;
    push_cycle15();
    pop_n(8);
    chk("strobe_count", strobes, 4);

    // cycle 5: reset in S_YEL at remain 2
    push(3'd0, 15, 0); push(3'd1, 4, 1);
    push(3'd2, 15, 0); push(3'd3, 4, 1);
    push(3'd4, 15, 0);
    push(3'd5, 4, 1, 0, 0, 8'd0, 2);
    pop_n(6);
    chk("midrst_hit", reset_hit, 1'b1);
    chk("midrst_ps", p_s, 3'd0);
    chk("midrst_remain", remain, 8'd54);
    chk("midrst_light_n", light_n, 2'b10);
    chk("midrst_light_s", light_s, 2'b00);
    chk("midrst_strobe", adapt_strobe, 1'b0);
    step();
    chk("midrst_hold_ps", p_s, 3'd0);
    chk("midrst_hold_remain", remain, 8'd54);
    reset_n = 1'b1;
    push(3'd0, 54, 0); push(3'd1, 4, 1);
    pop_n(2);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
